// File: rtl/pipe_cla_addsub_pkg.sv
// rtl/pipe_cla_addsub_pkg.sv - shared op encodings, group width and carry-in helper for pipe_cla_addsub
package pipe_cla_addsub_pkg;

    localparam int GROUP_W = 4;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDS = 2'b10;
    localparam logic [1:0] OP_SUBS = 2'b11;

    // Subtracts add ~b + 1; only plain ADD honours the external carry-in.
    function automatic logic eff_cin(input logic [1:0] op, input logic cin);
        case (op)
            OP_ADD:  return cin;
            OP_ADDS: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/pipe_cla_addsub_cla_group4.sv
// rtl/pipe_cla_addsub_cla_group4.sv - 4-bit carry-lookahead group (a, b, cin -> s, pp, gg)
// Ports: a, b   group operand bits
//        cin    carry into bit 0
//        s      group sum
//        pp, gg group propagate / generate (independent of cin)
module cla_group4
    import pipe_cla_addsub_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] s,
    output logic               pp,
    output logic               gg
);

    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign s  = p ^ c;
    assign pp = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/pipe_cla_addsub.sv
// rtl/pipe_cla_addsub.sv - pipelined carry-lookahead add/sub with signed saturation and NZVC flags
// Ports: clk, rst (async, active-high)
//        in_valid/in_ready, in_a, in_b, in_cin, in_op (00 ADD, 01 SUB, 10 ADDS, 11 SUBS)
//        out_valid/out_ready, out_s, out_n, out_z, out_v, out_c
module pipe_cla_addsub
    import pipe_cla_addsub_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_n,
    output logic             out_z,
    output logic             out_v,
    output logic             out_c
);

    localparam int SW     = GROUP_W * GROUPS_PER_STAGE;
    localparam int STAGES = WIDTH / SW;

    if ((WIDTH % SW) != 0 || WIDTH < SW) begin : g_bad_width
        $error("pipe_cla_addsub: WIDTH must be a non-zero multiple of 4*GROUPS_PER_STAGE");
    end

    // Single global stall: every register moves together or holds together.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * SW;      // first result bit produced by this stage
        localparam int RW = WIDTH - LO;  // operand bits still pending at this stage

        logic                        vi;
        logic                        sati;
        logic                        ci;
        logic [RW-1:0]               ai;
        logic [RW-1:0]               bi;
        logic [LO+SW-1:0]            so;
        logic [SW-1:0]               gs;
        logic [GROUPS_PER_STAGE:0]   gc;
        logic [GROUPS_PER_STAGE-1:0] gp;
        logic [GROUPS_PER_STAGE-1:0] gg;
        logic                        acc;
        logic                        prop;

        // Stage 0 takes the port operands (B already inverted for subtracts);
        // later stages take the skewed upper bits from the previous register.
        if (k == 0) begin : g_in
            assign vi   = in_valid;
            assign sati = in_op[1];
            assign ci   = eff_cin(in_op, in_cin);
            assign ai   = in_a;
            assign bi   = in_op[0] ? ~in_b : in_b;
            assign so   = gs;
        end else begin : g_in
            assign vi   = g_st[k-1].g_reg.v_q;
            assign sati = g_st[k-1].g_reg.sat_q;
            assign ci   = g_st[k-1].g_reg.c_q;
            assign ai   = g_st[k-1].g_reg.a_q;
            assign bi   = g_st[k-1].g_reg.b_q;
            assign so   = {gs, g_st[k-1].g_reg.s_q};
        end

        // Group-level lookahead: each carry is a sum of products of the
        // group generates/propagates and the stage carry-in.
        always_comb begin
            gc    = '0;
            acc   = 1'b0;
            prop  = 1'b0;
            gc[0] = ci;
            for (int g = 0; g < GROUPS_PER_STAGE; g++) begin
                acc  = gg[g];
                prop = gp[g];
                for (int j = g - 1; j >= 0; j--) begin
                    acc  = acc | (prop & gg[j]);
                    prop = prop & gp[j];
                end
                gc[g+1] = acc | (prop & ci);
            end
        end

        for (genvar g = 0; g < GROUPS_PER_STAGE; g++) begin : g_grp
            cla_group4 u_grp (
                .a   (ai[g*GROUP_W +: GROUP_W]),
                .b   (bi[g*GROUP_W +: GROUP_W]),
                .cin (gc[g]),
                .s   (gs[g*GROUP_W +: GROUP_W]),
                .pp  (gp[g]),
                .gg  (gg[g])
            );
        end

        if (k < STAGES - 1) begin : g_reg
            logic             v_q;
            logic             sat_q;
            logic             c_q;
            logic [LO+SW-1:0] s_q;
            logic [RW-SW-1:0] a_q;
            logic [RW-SW-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q   <= 1'b0;
                    sat_q <= 1'b0;
                    c_q   <= 1'b0;
                    s_q   <= '0;
                    a_q   <= '0;
                    b_q   <= '0;
                end else if (advance) begin
                    v_q   <= vi;
                    sat_q <= sati;
                    c_q   <= gc[GROUPS_PER_STAGE];
                    s_q   <= so;
                    a_q   <= ai[RW-1:SW];
                    b_q   <= bi[RW-1:SW];
                end
            end
        end else begin : g_out
            logic [WIDTH-1:0] s_raw;
            logic [WIDTH-1:0] s_fin;
            logic             a_sign;
            logic             b_sign;
            logic             c_out;
            logic             v_raw;

            assign s_raw  = so;
            assign a_sign = ai[RW-1];
            assign b_sign = bi[RW-1];
            assign c_out  = gc[GROUPS_PER_STAGE];
            // Carry into the MSB is recovered from the MSB sum bit.
            assign v_raw  = (s_raw[WIDTH-1] ^ a_sign ^ b_sign) ^ c_out;

            always_comb begin
                s_fin = s_raw;
                if (sati && v_raw) begin
                    s_fin = a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    out_s     <= '0;
                    out_n     <= 1'b0;
                    out_z     <= 1'b0;
                    out_v     <= 1'b0;
                    out_c     <= 1'b0;
                end else if (advance) begin
                    out_valid <= vi;
                    out_s     <= s_fin;
                    out_n     <= s_fin[WIDTH-1];
                    out_z     <= (s_fin == '0);
                    out_v     <= v_raw;
                    out_c     <= c_out;
                end
            end
        end
    end

endmodule
